// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter for a shared 16:1 mux path.
// One grant at a time, bounded by a hold limit.
module mux16_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic        done,
    output logic [3:0]  sel,
    output logic [15:0] gnt,
    output logic        busy,
    output logic        timeout
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state;
    logic [3:0] ptr;
    logic [7:0] hcnt;

    logic [3:0] win;
    logic       found;
    logic [3:0] idx;

    logic       rel_wd;
    logic       rel_hold;
    logic       rel_any;

    // First requester at or above ptr, wrapping 15 -> 0.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < 16; i++) begin
            idx = ptr + 4'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign rel_wd   = ~req[sel];
    assign rel_hold = (hcnt == HOLD_LAST);
    assign rel_any  = done | rel_wd | rel_hold;

    // Grant FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            hcnt    <= '0;
            sel     <= '0;
            gnt     <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        state <= GRANT;
                        sel   <= win;
                        gnt   <= 16'b1 << win;
                        busy  <= 1'b1;
                        hcnt  <= '0;
                    end else begin
                        gnt  <= '0;
                        busy <= 1'b0;
                    end
                end
                GRANT: begin
                    if (rel_any) begin
                        state   <= IDLE;
                        gnt     <= '0;
                        busy    <= 1'b0;
                        ptr     <= sel + 4'd1;
                        timeout <= rel_hold & ~done & ~rel_wd;
                    end else if (hcnt != 8'hFF) begin
                        hcnt <= hcnt + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Bench for mux16_rr_arbiter: directed scenarios
// plus random traffic against a transaction model.
module tb_mux16_rr_arbiter;

    localparam int MAX_HOLD = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic        done;
    logic [3:0]  sel;
    logic [15:0] gnt;
    logic        busy;
    logic        timeout;

    int vectors = 0;
    int errors  = 0;

    // model: current owner, how many cycles it has held
    bit m_busy;
    bit m_to;
    int m_sel;
    int m_ptr;
    int m_age;

    mux16_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .sel     (sel),
        .gnt     (gnt),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic model_step();
        int j;
        if (rst) begin
            m_busy = 0;
            m_to   = 0;
            m_sel  = 0;
            m_ptr  = 0;
            m_age  = 0;
        end else begin
            m_to = 0;
            if (!m_busy) begin
                if (req != 16'h0) begin
                    j = 0;
                    while (!req[(m_ptr + j) % 16]) j++;
                    m_sel  = (m_ptr + j) % 16;
                    m_busy = 1;
                    m_age  = 1;
                end
            end else if (done || !req[m_sel] ||
                         m_age == MAX_HOLD) begin
                m_to   = !done && req[m_sel] &&
                         m_age == MAX_HOLD;
                m_busy = 0;
                m_ptr  = (m_sel + 1) % 16;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic tick();
        logic [31:0] eg;
        @(posedge clk);
        model_step();
        #1;
        eg = m_busy ? (32'd1 << m_sel) : 32'd0;
        check("gnt", 32'(gnt), eg);
        check("sel", 32'(sel), 32'(m_sel));
        check("busy", 32'(busy), 32'(m_busy));
        check("timeout", 32'(timeout), 32'(m_to));
    endtask

    initial begin
        int n;
        int tos;
        bit pb;

        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        tick();
        tick();
        check("rst_sel", 32'(sel), 32'd0);
        rst = 1'b0;

        // idle with no requests
        for (int i = 0; i < 5; i++) tick();
        check("s1_gnt", 32'(gnt), 32'd0);

        // single requester, done after 3 cycles
        req = 16'h0020;
        tick();
        check("s2_gnt", 32'(gnt), 32'h0020);
        check("s2_sel", 32'(sel), 32'd5);
        tick();
        tick();
        done = 1'b1;
        tick();
        check("s2_rel", 32'(busy), 32'd0);
        done = 1'b0;
        req  = 16'hFFFF;
        tick();
        tick();
        check("s2_ptr6", 32'(sel), 32'd6);

        // all requesting, hold limit, rotation
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n   = 0;
        tos = 0;
        pb  = 1'b0;
        for (int i = 0; i < 9 * 17; i++) begin
            tick();
            if (busy && !pb) begin
                check("s3_rot", 32'(sel), 32'(n % 16));
                n++;
            end
            if (timeout) tos++;
            pb = busy;
        end
        check("s3_grants", 32'(n), 32'd17);
        check("s3_tos", 32'(tos), 32'd17);

        // wrap 15 -> 0 -> 15
        req = 16'h0;
        tick();
        tick();
        req = 16'h4000;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 16'h8001;
        tick();
        check("s4_g15", 32'(sel), 32'd15);
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        check("s4_g0", 32'(sel), 32'd0);
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        check("s4_g15b", 32'(sel), 32'd15);
        done = 1'b1;
        tick();
        done = 1'b0;

        // withdrawal at hcnt=2
        rst = 1'b1;
        req = 16'h0008;
        tick();
        rst = 1'b0;
        tick();
        check("s5_gnt", 32'(gnt), 32'h0008);
        tick();
        tick();
        req = 16'h0;
        tick();
        check("s5_busy", 32'(busy), 32'd0);
        check("s5_to", 32'(timeout), 32'd0);

        // reset mid-grant, then search from 0
        req = 16'h0200;
        tick();
        tick();
        check("s6_sel9", 32'(sel), 32'd9);
        rst = 1'b1;
        tick();
        check("s6_sel", 32'(sel), 32'd0);
        check("s6_gnt", 32'(gnt), 32'd0);
        rst = 1'b0;
        req = 16'h0600;
        tick();
        check("s6_regnt", 32'(sel), 32'd9);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0)
                req = 16'($urandom) & 16'($urandom);
            done = ($urandom_range(0, 7) == 0);
            rst  = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule

// File: doc/mux16_rr_arbiter.md
MUX16_RR_ARBITER -- requirements
Module: mux16_rr_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 8, which is the maximum number of cycles one grant is held; legal range is 2..255.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port req, input, 16 bits: request vector, where bit i is requester i asking for the shared 16:1 mux path.
REQ-005 SHALL have port done, input, 1 bit: the consumer has finished with the current grant and it is released.
REQ-006 SHALL have port sel, output, 4 bits: binary index of the granted requester, which drives the mux select.
REQ-007 SHALL have port gnt, output, 16 bits: one-hot grant vector, all-zero when idle.
REQ-008 SHALL have port busy, output, 1 bit: high while a grant is active.
REQ-009 SHALL have port timeout, output, 1 bit: one-cycle pulse when a grant is force-released by the hold limit.

Function
REQ-010 SHALL implement a two-state FSM with states IDLE and GRANT, plus a 4-bit round-robin pointer ptr and an 8-bit hold counter hcnt; all outputs SHALL be registered.
REQ-011 In IDLE with req != 0, SHALL select the first set bit of req searching upward from ptr with wrap 15->0, and enter GRANT on the next edge.
REQ-012 On entering GRANT with winner k, SHALL set sel=k, gnt=(1<<k), busy=1, hcnt=0; grant latency is one cycle from a sampled req to gnt.
REQ-013 In IDLE with req == 0, SHALL remain in IDLE with gnt=0 and busy=0; sel SHALL hold its last value.
REQ-014 In GRANT, hcnt SHALL increment by 1 each cycle and SHALL never wrap.
REQ-015 In GRANT, SHALL release when any of the following is true: (a) done=1, (b) req[sel]=0 (requester withdrew), or (c) hcnt == MAX_HOLD-1.
REQ-016 On release, SHALL go to IDLE, drive gnt=0 and busy=0 on the next edge, and set ptr=(sel+1) mod 16 (so 15 wraps to 0).
REQ-017 timeout SHALL be 1 for exactly the cycle after a release caused solely by condition (c); if done=1 or req[sel]=0 in the same cycle as (c), timeout SHALL stay 0.
REQ-018 After any release, SHALL spend exactly one cycle in IDLE before the next grant, so back-to-back grants are separated by one idle cycle.
REQ-019 Changes to req bits other than req[sel] during GRANT SHALL NOT affect the current grant.
REQ-020 gnt SHALL always be one-hot or zero and equal (1<<sel) whenever busy=1.
REQ-021 With all 16 requesters continuously requesting, grants SHALL rotate 0,1,...,15,0 and no requester SHALL wait more than 15 grant periods.

Reset
REQ-022 When rst=1 at a rising edge, SHALL set state=IDLE, ptr=0, hcnt=0, sel=0, gnt=0, busy=0, timeout=0, overriding every other input.
REQ-023 Reset asserted mid-GRANT SHALL abort the grant with no timeout pulse; the first arbitration after reset SHALL start its search at index 0.

Verification
REQ-024 Scenario 1: after reset, req=16'h0000 for 5 cycles -> gnt=0, busy=0, sel=0 throughout.
REQ-025 Scenario 2: req=16'h0020 with done pulsed 3 cycles after the grant -> gnt=16'h0020 and sel=5 one cycle after req, busy=1, release one cycle after done, next search starts at ptr=6.
REQ-026 Scenario 3: req=16'hFFFF held, done=0, MAX_HOLD=8 -> each grant lasts 8 cycles with a timeout pulse, and sel sequences 0,1,2,...,15,0.
REQ-027 Scenario 4: ptr=15, req=16'h8001 -> grant 15, then after release grant 0 (wrap), then grant 15 again.
REQ-028 Scenario 5: requester 3 is granted and req[3] drops at hcnt=2 -> release on the next edge, timeout=0, ptr=4.
REQ-029 Scenario 6: rst=1 asserted mid-grant with sel=9 -> the next cycle shows gnt=0, sel=0, busy=0, timeout=0, and req=16'h0600 then grants index 9 (search from 0).
